// File: rtl/bsg_dff_chain_credit_sink_if.sv
// Link between a bsg_dff_chain output, its credit sink buffer and the consumer.
// The slave modport is the sink; the master modport is the sender/consumer side.
interface bsg_dff_chain_credit_sink_if #(
    parameter int width_p = 27,
    parameter int els_p   = 4
);
    localparam int cnt_w = $clog2(els_p + 1);

    logic               v_i;
    logic [width_p-1:0] data_i;
    logic               v_o;
    logic [width_p-1:0] data_o;
    logic               yumi_i;
    logic               credit_o;
    logic [cnt_w-1:0]   count_o;
    logic               overflow_o;

    modport slave (
        input  v_i,
        input  data_i,
        input  yumi_i,
        output v_o,
        output data_o,
        output credit_o,
        output count_o,
        output overflow_o
    );

    modport master (
        output v_i,
        output data_i,
        output yumi_i,
        input  v_o,
        input  data_o,
        input  credit_o,
        input  count_o,
        input  overflow_o
    );
endinterface

// File: rtl/bsg_dff_chain_credit_sink.sv
// Receive end of a credit-managed bsg_dff_chain: circular buffer plus credit return.
// Optional zero-latency empty bypass is enabled by defining BSG_DFF_CHAIN_SINK_BYPASS_EN.
module bsg_dff_chain_credit_sink #(
    parameter int width_p = 27,
    parameter int els_p   = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    bsg_dff_chain_credit_sink_if.slave link
);
    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = $clog2(els_p + 1);

    logic [width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]   rd_ptr;
    logic [ptr_w-1:0]   wr_ptr;
    logic [cnt_w-1:0]   count;
    logic               credit_r;
    logic               overflow_r;

    logic empty;
    logic full;
    logic deq;
    logic buf_deq;
    logic enq;
    logic drop;
    logic bypass_take;

    assign empty = (count == '0);
    assign full  = (count == cnt_w'(els_p));

`ifdef BSG_DFF_CHAIN_SINK_BYPASS_EN
    // An arriving word is visible immediately when nothing older is waiting.
    assign link.v_o    = !empty || link.v_i;
    assign link.data_o = empty ? link.data_i : mem[rd_ptr];
    assign bypass_take = empty && link.v_i && link.yumi_i;
`else
    assign link.v_o    = !empty;
    assign link.data_o = mem[rd_ptr];
    assign bypass_take = 1'b0;
`endif

    assign deq     = link.v_o && link.yumi_i;
    assign buf_deq = deq && !empty;
    // A full buffer still accepts a word when a slot frees in the same cycle.
    assign enq     = link.v_i && !bypass_take && (!full || deq);
    assign drop    = link.v_i && full && !deq;

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wr_ptr] <= link.data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            credit_r   <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= (wr_ptr == ptr_w'(els_p - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (buf_deq) begin
                rd_ptr <= (rd_ptr == ptr_w'(els_p - 1)) ? '0 : rd_ptr + 1'b1;
            end
            count    <= count + cnt_w'(enq) - cnt_w'(buf_deq);
            credit_r <= deq;
            if (drop) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign link.credit_o   = credit_r;
    assign link.count_o    = count;
    assign link.overflow_o = overflow_r;
endmodule
